if_fetch_decode: RTL and testbench

Instruction fetch and field-decode stage for the 8-bit pipelined microprocessor. Owns the program counter, reads the 64-word instruction ROM, splits each 16-bit instruction word into its fields, and registers them as the IF/ID pipeline register. It is the producer of every IF_ID_* field consumed by the ID/EX latch. It also handles stall, branch redirect and halt.

---
 rtl/if_fetch_decode.sv | 139 +++++++++++++
 tb/tb_if_fetch_decode.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_decode.sv
// Instruction fetch and field-decode stage.
// Owns the program counter, reads the instruction ROM asynchronously and
// registers the raw field slices of each fetched word as the IF/ID latch.
// Handles stall, branch redirect and halt.
module if_fetch_decode #(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter logic [4:0]  HLT_OPCODE = 5'b11111,
    parameter logic [4:0]  NOP_OPCODE = 5'b00000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          branch_taken,
    input  logic [$clog2(IMEM_DEPTH)-1:0] branch_target,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [15:0]                   imem_rdata,
    output logic [4:0]                    IF_ID_opcode,
    output logic                          IF_ID_addressing_mode,
    output logic [2:0]                    IF_ID_rd,
    output logic [2:0]                    IF_ID_rs1,
    output logic [2:0]                    IF_ID_rs2,
    output logic [3:0]                    IF_ID_data_mem,
    output logic [5:0]                    IF_ID_instruction_mem,
    output logic [2:0]                    IF_ID_s_r_amount,
    output logic                          IF_ID_valid,
    output logic [$clog2(IMEM_DEPTH)-1:0] IF_ID_pc,
    output logic                          halted
);

    localparam int unsigned PC_W = $clog2(IMEM_DEPTH);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    // Contents of the IF/ID pipeline register. Fields overlap by design;
    // downstream stages pick the ones that matter for the opcode.
    typedef struct packed {
        logic [4:0]      opcode;
        logic            addressing_mode;
        logic [2:0]      rd;
        logic [2:0]      rs1;
        logic [2:0]      rs2;
        logic [3:0]      data_mem;
        logic [5:0]      instruction_mem;
        logic [2:0]      s_r_amount;
        logic            valid;
        logic [PC_W-1:0] pc;
    } ifid_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    ifid_t           ifid_q, ifid_d;

    // Empty slot: no instruction, NOP opcode, every other field zero.
    function automatic ifid_t bubble();
        ifid_t b;
        b        = '0;
        b.opcode = NOP_OPCODE;
        return b;
    endfunction

    // Raw slices of one instruction word, tagged with its fetch address.
    function automatic ifid_t split_word(input logic [15:0] w,
                                         input logic [PC_W-1:0] addr);
        ifid_t f;
        f.opcode          = w[15:11];
        f.addressing_mode = w[10];
        f.rd              = w[9:7];
        f.rs1             = w[6:4];
        f.rs2             = w[3:1];
        f.data_mem        = w[3:0];
        f.instruction_mem = w[5:0];
        f.s_r_amount      = w[2:0];
        f.valid           = 1'b1;
        f.pc              = addr;
        return f;
    endfunction

    // Next-state logic: branch beats stall, stall freezes everything,
    // otherwise fetch in RUN or emit bubbles in HALTED.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        if (branch_taken) begin
            ifid_d  = bubble();
            pc_d    = branch_target;
            state_d = RUN;
        end else if (!stall) begin
            case (state_q)
                RUN: begin
                    ifid_d = split_word(imem_rdata, pc_q);
                    if (imem_rdata[15:11] == HLT_OPCODE) begin
                        state_d = HALTED;
                    end else begin
                        // PC width equals log2 of the ROM depth, so the
                        // natural overflow gives the modulo wrap.
                        pc_d = pc_q + PC_W'(1);
                    end
                end
                HALTED: begin
                    ifid_d = bubble();
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State, PC and IF/ID register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= '0;
            ifid_q  <= bubble();
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
        end
    end

    assign imem_addr             = pc_q;
    assign halted                = (state_q == HALTED);
    assign IF_ID_opcode          = ifid_q.opcode;
    assign IF_ID_addressing_mode = ifid_q.addressing_mode;
    assign IF_ID_rd              = ifid_q.rd;
    assign IF_ID_rs1             = ifid_q.rs1;
    assign IF_ID_rs2             = ifid_q.rs2;
    assign IF_ID_data_mem        = ifid_q.data_mem;
    assign IF_ID_instruction_mem = ifid_q.instruction_mem;
    assign IF_ID_s_r_amount      = ifid_q.s_r_amount;
    assign IF_ID_valid           = ifid_q.valid;
    assign IF_ID_pc              = ifid_q.pc;

endmodule

// File: tb/tb_if_fetch_decode.sv
// Directed bench for if_fetch_decode: a vector table walked one clock per
// row, then hand-written sequences for field decode and halt/stall corners.
module tb_if_fetch_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [5:0]  branch_target = '0;
    logic [5:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [4:0]  IF_ID_opcode;
    logic        IF_ID_addressing_mode;
    logic [2:0]  IF_ID_rd, IF_ID_rs1, IF_ID_rs2, IF_ID_s_r_amount;
    logic [3:0]  IF_ID_data_mem;
    logic [5:0]  IF_ID_instruction_mem;
    logic        IF_ID_valid;
    logic [5:0]  IF_ID_pc;
    logic        halted;

    logic [15:0] rom [64];
    int unsigned checks = 0;
    int unsigned errors = 0;

    if_fetch_decode #(
        .IMEM_DEPTH(64),
        .HLT_OPCODE(5'b11111),
        .NOP_OPCODE(5'b00000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .IF_ID_opcode(IF_ID_opcode),
        .IF_ID_addressing_mode(IF_ID_addressing_mode),
        .IF_ID_rd(IF_ID_rd),
        .IF_ID_rs1(IF_ID_rs1),
        .IF_ID_rs2(IF_ID_rs2),
        .IF_ID_data_mem(IF_ID_data_mem),
        .IF_ID_instruction_mem(IF_ID_instruction_mem),
        .IF_ID_s_r_amount(IF_ID_s_r_amount),
        .IF_ID_valid(IF_ID_valid),
        .IF_ID_pc(IF_ID_pc),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // Asynchronous ROM read.
    assign imem_rdata = rom[imem_addr];

    typedef struct {
        logic       rst;
        logic       stall;
        logic       br;
        logic [5:0] tgt;
        logic       e_valid;
        logic [5:0] e_ifpc;
        logic [5:0] e_addr;
        logic       e_halted;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] fields_of(input logic [15:0] w);
        return {w[15:11], w[10], w[9:7], w[6:4], w[3:1], w[3:0], w[5:0], w[2:0]};
    endfunction

    function automatic logic [32:0] dut_fields();
        return {IF_ID_opcode, IF_ID_addressing_mode, IF_ID_rd, IF_ID_rs1,
                IF_ID_rs2, IF_ID_data_mem, IF_ID_instruction_mem, IF_ID_s_r_amount};
    endfunction

    task automatic step(input logic r, input logic s, input logic b,
                        input logic [5:0] t);
        @(negedge clk);
        rst = r; stall = s; branch_taken = b; branch_target = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 16'h1000 | 16'(i);
        rom[0]  = 16'h0A92;
        rom[1]  = 16'h1234;
        rom[2]  = 16'h2FFF;
        rom[10] = 16'hF800;

        //            rst   stall br    tgt    valid ifpc   addr   halted
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  6'd0,  1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd0,  6'd1,  1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd1,  6'd2,  1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd2,  6'd3,  1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd3,  6'd4,  1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd4,  6'd5,  1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 6'd0,  1'b1, 6'd4,  6'd5,  1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 6'd0,  1'b1, 6'd4,  6'd5,  1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 6'd0,  1'b1, 6'd4,  6'd5,  1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd5,  6'd6,  1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 6'd40, 1'b0, 6'd0,  6'd40, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd40, 6'd41, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 6'd62, 1'b0, 6'd0,  6'd62, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd62, 6'd63, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd63, 6'd0,  1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 6'd9,  1'b0, 6'd0,  6'd9,  1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd9,  6'd10, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd10, 6'd10, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  6'd10, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  6'd10, 1'b1};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  6'd10, 1'b1};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  6'd10, 1'b1};
        tbl[22] = '{1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 6'd0,  6'd10, 1'b1};
        tbl[23] = '{1'b0, 1'b0, 1'b1, 6'd12, 1'b0, 6'd0,  6'd12, 1'b0};
        tbl[24] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd12, 6'd13, 1'b0};
        tbl[25] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd13, 6'd14, 1'b0};
        tbl[26] = '{1'b1, 1'b1, 1'b1, 6'd30, 1'b0, 6'd0,  6'd0,  1'b0};
        tbl[27] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd0,  6'd1,  1'b0};

        for (int i = 0; i < NV; i++) begin
            logic [15:0] w;
            step(tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].tgt);
            w = tbl[i].e_valid ? rom[tbl[i].e_ifpc] : 16'h0000;
            check($sformatf("v%0d valid", i), 64'(IF_ID_valid), 64'(tbl[i].e_valid));
            check($sformatf("v%0d if_id_pc", i), 64'(IF_ID_pc), 64'(tbl[i].e_ifpc));
            check($sformatf("v%0d imem_addr", i), 64'(imem_addr), 64'(tbl[i].e_addr));
            check($sformatf("v%0d halted", i), 64'(halted), 64'(tbl[i].e_halted));
            check($sformatf("v%0d fields", i), 64'(dut_fields()), 64'(fields_of(w)));
        end

        // Field decode of the first word after reset (ROM[0] = 16'h0A92).
        step(1'b1, 1'b0, 1'b0, 6'd0);
        step(1'b0, 1'b0, 1'b0, 6'd0);
        check("w0 opcode", 64'(IF_ID_opcode), 64'h01);
        check("w0 addressing_mode", 64'(IF_ID_addressing_mode), 64'h0);
        check("w0 rd", 64'(IF_ID_rd), 64'd5);
        check("w0 rs1", 64'(IF_ID_rs1), 64'd1);
        check("w0 rs2", 64'(IF_ID_rs2), 64'd1);
        check("w0 data_mem", 64'(IF_ID_data_mem), 64'h2);
        check("w0 instruction_mem", 64'(IF_ID_instruction_mem), 64'h12);
        check("w0 s_r_amount", 64'(IF_ID_s_r_amount), 64'h2);

        // Stall right after the HLT fetch keeps the valid HLT in IF/ID.
        step(1'b0, 1'b0, 1'b1, 6'd10);
        step(1'b0, 1'b0, 1'b0, 6'd0);
        check("hlt opcode", 64'(IF_ID_opcode), 64'h1F);
        check("hlt valid", 64'(IF_ID_valid), 64'h1);
        check("hlt halted", 64'(halted), 64'h1);
        step(1'b0, 1'b1, 1'b0, 6'd0);
        check("hlt stall valid", 64'(IF_ID_valid), 64'h1);
        check("hlt stall opcode", 64'(IF_ID_opcode), 64'h1F);
        check("hlt stall addr", 64'(imem_addr), 64'd10);
        step(1'b0, 1'b0, 1'b0, 6'd0);
        check("hlt bubble valid", 64'(IF_ID_valid), 64'h0);
        check("hlt bubble opcode", 64'(IF_ID_opcode), 64'h00);
        check("hlt bubble halted", 64'(halted), 64'h1);

        // Branch with stall while halted: branch wins and fetch resumes.
        step(1'b0, 1'b1, 1'b1, 6'd12);
        check("resume halted", 64'(halted), 64'h0);
        check("resume addr", 64'(imem_addr), 64'd12);
        step(1'b0, 1'b0, 1'b0, 6'd0);
        check("resume ifpc", 64'(IF_ID_pc), 64'd12);
        check("resume valid", 64'(IF_ID_valid), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
